depth_line_buffer: RTL and testbench

- Sits directly downstream of the 64-bit column mask generator (2-bit distance placed at bit position 2*col).
- Accumulates one sweep of masks into a working line (32 columns x 2 bits), then hands the completed line to the renderer through a double buffer.
- Renderer reads per-column distance by column index while the next line accumulates.
- Single clock domain: clk, synchronous active-high reset.

---
 rtl/depth_line_buffer_pkg.sv | 30 +++
 rtl/depth_line_buffer_col_select.sv | 31 +++
 rtl/depth_line_buffer.sv | 119 +++++++++++
 tb/tb_depth_line_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/depth_line_buffer_pkg.sv
// ---------------------------------------------------------------------------
// depth_line_buffer_pkg : shared depth-line constants, FSM states, column map
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package depth_line_buffer_pkg;

   localparam int COLS   = 32;
   localparam int DW     = 2;
   localparam int LINE_W = COLS * DW;
   localparam int CNT_W  = 6;
   localparam int COL_W  = $clog2(COLS);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACCUM     = 2'd1,
      SWAP_WAIT = 2'd2
   } state_e;

   // Same column-to-bit rule the mask generator uses to place a distance.
   function automatic int unsigned col_offset(input logic [COL_W-1:0] col);
      return DW * int'(col);
   endfunction

endpackage

`default_nettype wire

// File: rtl/depth_line_buffer_col_select.sv
// ---------------------------------------------------------------------------
// depth_col_select : registered column-read mux over the display line
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module depth_col_select
   import depth_line_buffer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [LINE_W-1:0] disp_i,
   input  logic [COL_W-1:0]  rd_col_i,
   output logic [DW-1:0]     rd_dist_o
);

   logic [DW-1:0] rd_dist_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_dist_q <= '0;
      end else begin
         rd_dist_q <= disp_i[col_offset(rd_col_i) +: DW];
      end
   end

   assign rd_dist_o = rd_dist_q;

endmodule

`default_nettype wire

// File: rtl/depth_line_buffer.sv
// ---------------------------------------------------------------------------
// depth_line_buffer : accumulates column masks into a line, double-buffers it
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module depth_line_buffer
   import depth_line_buffer_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              line_start,
   input  logic [LINE_W-1:0] mask_in,
   input  logic              mask_valid,
   output logic              mask_ready,
   input  logic              line_done,
   output logic              line_ready,
   input  logic              line_ack,
   input  logic [COL_W-1:0]  rd_col,
   output logic [DW-1:0]     rd_dist,
   output logic [CNT_W-1:0]  line_count,
   output logic              overlap_err
);

   state_e              state_q;
   logic [LINE_W-1:0]   work_q;
   logic [LINE_W-1:0]   disp_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    line_count_q;
   logic                line_ready_q;
   logic                overlap_q;

   logic                accept;
   logic                buf_free;
   logic [LINE_W-1:0]   work_d;
   logic [CNT_W-1:0]    cnt_d;

   assign mask_ready = (state_q == ACCUM);
   assign accept     = mask_valid & mask_ready;
   assign buf_free   = ~line_ready_q | line_ack;

   // Line contents as they stand after this cycle's mask, so a mask arriving
   // together with line_done is part of the published line.
   assign work_d = accept ? (work_q | mask_in) : work_q;
   assign cnt_d  = (accept && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         work_q       <= '0;
         disp_q       <= '0;
         cnt_q        <= '0;
         line_count_q <= '0;
         line_ready_q <= 1'b0;
         overlap_q    <= 1'b0;
      end else begin
         if (line_ack) begin
            line_ready_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (line_start) begin
                  work_q    <= '0;
                  cnt_q     <= '0;
                  overlap_q <= 1'b0;
                  state_q   <= ACCUM;
               end
            end
            ACCUM: begin
               if (line_start) begin
                  work_q    <= '0;
                  cnt_q     <= '0;
                  overlap_q <= 1'b0;
               end else begin
                  work_q <= work_d;
                  cnt_q  <= cnt_d;
                  if (accept && |(work_q & mask_in)) begin
                     overlap_q <= 1'b1;
                  end
                  if (line_done) begin
                     if (buf_free) begin
                        disp_q       <= work_d;
                        line_count_q <= cnt_d;
                        line_ready_q <= 1'b1;
                        state_q      <= IDLE;
                     end else begin
                        state_q <= SWAP_WAIT;
                     end
                  end
               end
            end
            SWAP_WAIT: begin
               if (line_ack) begin
                  disp_q       <= work_q;
                  line_count_q <= cnt_q;
                  line_ready_q <= 1'b1;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   depth_col_select u_col_select (
      .clk       (clk),
      .reset     (reset),
      .disp_i    (disp_q),
      .rd_col_i  (rd_col),
      .rd_dist_o (rd_dist)
   );

   assign line_ready  = line_ready_q;
   assign line_count  = line_count_q;
   assign overlap_err = overlap_q;

endmodule

`default_nettype wire

// File: tb/tb_depth_line_buffer.sv
// ---------------------------------------------------------------------------
// tb_depth_line_buffer : scoreboard bench with a per-column reference model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_depth_line_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        line_start;
   logic [63:0] mask_in;
   logic        mask_valid;
   logic        mask_ready;
   logic        line_done;
   logic        line_ready;
   logic        line_ack;
   logic [4:0]  rd_col;
   logic [1:0]  rd_dist;
   logic [5:0]  line_count;
   logic        overlap_err;

   always #5 clk = ~clk;

   depth_line_buffer dut (
      .clk         (clk),
      .reset       (reset),
      .line_start  (line_start),
      .mask_in     (mask_in),
      .mask_valid  (mask_valid),
      .mask_ready  (mask_ready),
      .line_done   (line_done),
      .line_ready  (line_ready),
      .line_ack    (line_ack),
      .rd_col      (rd_col),
      .rd_dist     (rd_dist),
      .line_count  (line_count),
      .overlap_err (overlap_err)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit mr;
      bit lr;
      int lc;
      bit ov;
      int rd;
   } exp_t;

   exp_t sb[$];

   // Reference model: per-column distances, a sweep flag and a pending flag.
   int unsigned m_work[32];
   int unsigned m_disp[32];
   int          m_cnt, m_lc;
   bit          m_collect, m_pending, m_lr, m_ovl;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_sweep();
      for (int c = 0; c < 32; c++) m_work[c] = 0;
      m_cnt = 0;
      m_ovl = 0;
   endtask

   task automatic model_step(input bit rst, input bit ls, input bit mv, input logic [63:0] m,
                             input bit ld, input bit ack, input int col);
      exp_t e;
      bit   swap;
      int   rdv;
      swap = 0;
      rdv  = int'(m_disp[col]);
      if (rst) begin
         clear_sweep();
         for (int c = 0; c < 32; c++) m_disp[c] = 0;
         m_lc = 0; m_lr = 0; m_collect = 0; m_pending = 0;
         rdv = 0;
      end else begin
         if (m_pending) begin
            if (ack) swap = 1;
         end else if (m_collect) begin
            if (ls) begin
               clear_sweep();
            end else begin
               if (mv) begin
                  for (int c = 0; c < 32; c++) begin
                     int unsigned f;
                     f = int'((m >> (2 * c)) & 64'h3);
                     if ((m_work[c] & f) != 0) m_ovl = 1;
                     m_work[c] = m_work[c] | f;
                  end
                  m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
               end
               if (ld) begin
                  if (!m_lr || ack) swap = 1;
                  else m_pending = 1;
               end
            end
         end else if (ls) begin
            m_collect = 1;
            clear_sweep();
         end
         if (swap) begin
            for (int c = 0; c < 32; c++) m_disp[c] = m_work[c];
            m_lc = m_cnt; m_lr = 1; m_collect = 0; m_pending = 0;
         end else if (ack) begin
            m_lr = 0;
         end
      end
      e.mr = m_collect && !m_pending;
      e.lr = m_lr;
      e.lc = m_lc;
      e.ov = m_ovl;
      e.rd = rdv;
      sb.push_back(e);
   endtask

   // Drive one clock cycle of inputs, predict, then return #1 after the edge.
   task automatic cyc(input bit rst, input bit ls, input bit mv, input logic [63:0] m,
                      input bit ld, input bit ack, input int col);
      @(negedge clk);
      reset      = rst;
      line_start = ls;
      mask_valid = mv;
      mask_in    = m;
      line_done  = ld;
      line_ack   = ack;
      rd_col     = 5'(col);
      model_step(rst, ls, mv, m, ld, ack, col);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int col);
      cyc(0, 0, 0, 64'h0, 0, 0, col);
   endtask

   task automatic push_mask(input logic [63:0] m);
      cyc(0, 0, 1, m, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("sb_mask_ready", 64'(mask_ready), 64'(e.mr));
            cmp("sb_line_ready", 64'(line_ready), 64'(e.lr));
            cmp("sb_line_count", 64'(line_count), 64'(e.lc));
            cmp("sb_overlap",    64'(overlap_err), 64'(e.ov));
            cmp("sb_rd_dist",    64'(rd_dist), 64'(e.rd));
         end
      end
   end

   initial begin : stim
      reset = 1; line_start = 0; mask_valid = 0; mask_in = '0;
      line_done = 0; line_ack = 0; rd_col = '0;
      clear_sweep();
      for (int c = 0; c < 32; c++) m_disp[c] = 0;
      m_lc = 0; m_lr = 0; m_collect = 0; m_pending = 0;

      cyc(1, 0, 0, 64'h0, 0, 0, 0);
      cyc(1, 1, 1, 64'hF, 1, 1, 0);
      cmp("rst_mask_ready", 64'(mask_ready), 64'd0);
      cmp("rst_line_ready", 64'(line_ready), 64'd0);
      cmp("rst_rd_dist",    64'(rd_dist), 64'd0);

      // Basic sweep of three columns.
      cyc(0, 1, 0, 64'h0, 0, 0, 0);
      push_mask(64'h3);
      push_mask(64'h4);
      push_mask(64'h8000_0000_0000_0000);
      cyc(0, 0, 0, 64'h0, 1, 0, 0);
      cmp("pub_line_ready", 64'(line_ready), 64'd1);
      cmp("pub_line_count", 64'(line_count), 64'd3);
      idle(0);
      cmp("rd_col0", 64'(rd_dist), 64'd3);
      idle(1);
      cmp("rd_col1", 64'(rd_dist), 64'd1);
      idle(31);
      cmp("rd_col31", 64'(rd_dist), 64'd2);
      cmp("no_overlap", 64'(overlap_err), 64'd0);

      // Overlap detection, sticky through publish (line A).
      cyc(0, 0, 0, 64'h0, 0, 1, 0);
      cmp("ack_clears_ready", 64'(line_ready), 64'd0);
      cyc(0, 1, 0, 64'h0, 0, 0, 0);
      push_mask(64'h3);
      push_mask(64'h1);
      cmp("overlap_set", 64'(overlap_err), 64'd1);
      cyc(0, 0, 0, 64'h0, 1, 0, 0);
      cmp("overlap_after_done", 64'(overlap_err), 64'd1);
      cyc(0, 1, 0, 64'h0, 0, 0, 0);
      cmp("overlap_cleared", 64'(overlap_err), 64'd0);

      // Line B while A unconsumed: stalls in swap wait.
      push_mask(64'hC);
      push_mask(64'h30);
      push_mask(64'hC0);
      cyc(0, 0, 0, 64'h0, 1, 0, 0);
      cmp("wait_mask_ready", 64'(mask_ready), 64'd0);
      cmp("wait_line_ready", 64'(line_ready), 64'd1);
      idle(0);
      cmp("wait_rd_old", 64'(rd_dist), 64'd3);
      cmp("wait_count_old", 64'(line_count), 64'd2);
      cyc(0, 0, 0, 64'h0, 0, 1, 1);
      cmp("swap_rd_old", 64'(rd_dist), 64'd0);
      idle(1);
      cmp("swap_rd_new", 64'(rd_dist), 64'd3);
      cmp("swap_count_new", 64'(line_count), 64'd3);
      cmp("swap_line_ready", 64'(line_ready), 64'd1);

      // Mask together with line_done; mask together with line_start.
      cyc(0, 1, 0, 64'h0, 0, 0, 0);
      cyc(0, 0, 1, 64'h30, 1, 1, 2);
      cmp("done_mask_count", 64'(line_count), 64'd1);
      idle(2);
      cmp("done_mask_col2", 64'(rd_dist), 64'd3);
      cyc(0, 1, 0, 64'h0, 0, 0, 0);
      cyc(0, 1, 1, 64'hFF, 0, 0, 0);
      cyc(0, 0, 0, 64'h0, 1, 1, 0);
      cmp("start_drops_mask", 64'(line_count), 64'd0);

      // Counter saturation.
      cyc(0, 1, 0, 64'h0, 0, 0, 0);
      repeat (70) push_mask(64'h0);
      cyc(0, 0, 0, 64'h0, 1, 1, 0);
      cmp("count_saturates", 64'(line_count), 64'd63);

      // Reset in the middle of a sweep.
      cyc(0, 1, 0, 64'h0, 0, 0, 0);
      repeat (5) push_mask(64'h3);
      cyc(1, 0, 0, 64'h0, 0, 0, 0);
      cmp("midrst_line_ready", 64'(line_ready), 64'd0);
      cmp("midrst_line_count", 64'(line_count), 64'd0);
      cmp("midrst_overlap", 64'(overlap_err), 64'd0);
      cyc(0, 0, 1, 64'h3, 0, 0, 0);
      cmp("idle_mask_ready", 64'(mask_ready), 64'd0);
      cyc(0, 0, 0, 64'h0, 0, 1, 0);
      cmp("stray_ack", 64'(line_ready), 64'd0);
      cyc(0, 1, 0, 64'h0, 0, 0, 0);
      cyc(0, 0, 0, 64'h0, 1, 0, 0);
      cmp("idle_mask_ignored", 64'(line_count), 64'd0);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [63:0] m;
         if ($urandom_range(1, 0) == 1)
            m = 64'($urandom_range(3, 0)) << (2 * $urandom_range(31, 0));
         else
            m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         cyc(($urandom % 300) == 0, ($urandom % 25) == 0, ($urandom % 3) != 0, m,
             ($urandom % 18) == 0, ($urandom % 6) == 0, int'($urandom_range(31, 0)));
      end

      idle(0);
      idle(0);
      cmp("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
